// File: rtl/vmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmem_pkg
// Brief    : Shared widths, pixel/address types and address-packing helpers
//            for the video-memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package vmem_pkg;

  // Default widths used by the arbiter parameters
  localparam int VMEM_ADDR_W = 19;
  localparam int VMEM_DATA_W = 24;
  localparam int VMEM_CNT_W  = 16;

  // Pixel address layout: {h_addr, v_addr}
  localparam int H_BITS = 10;
  localparam int V_BITS = 9;

  typedef logic [VMEM_DATA_W-1:0] pixel_t;
  typedef logic [H_BITS+V_BITS-1:0] vaddr_t;

  // Round-robin pointer: which writer wins the next tie
  typedef enum logic {
    RR_W0 = 1'b0,
    RR_W1 = 1'b1
  } rr_sel_e;

  // Build a pixel address from horizontal and vertical coordinates
  function automatic vaddr_t pack_addr(input logic [H_BITS-1:0] h,
                                       input logic [V_BITS-1:0] v);
    return {h, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter with enable. Holds the tie-break
//            pointer and produces a one-hot (or zero) grant combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import vmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  rr_sel_e    ptr_q;
  rr_sel_e    ptr_d;
  logic [1:0] gnt_d;

  // Grant a lone requester; on a tie, the pointer decides
  always_comb begin
    gnt_d = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_d = 2'b01;
        2'b10:   gnt_d = 2'b10;
        2'b11:   gnt_d = (ptr_q == RR_W1) ? 2'b10 : 2'b01;
        default: gnt_d = 2'b00;
      endcase
    end
  end

  // After a grant, point at the other writer; otherwise hold
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_d[0]) begin
      ptr_d = RR_W1;
    end else if (gnt_d[1]) begin
      ptr_d = RR_W0;
    end
  end

  // Pointer register; w0 is favoured on the first tie after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= RR_W0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_d;

endmodule
`default_nettype wire

// File: rtl/vmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vmem_arbiter
// Brief    : Single-port video-memory arbiter. Scan-out reads always win;
//            two writers share leftover cycles round-robin, optionally only
//            during vertical blanking. Tracks per-frame writer stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W,
  parameter int CNT_W  = VMEM_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  // scan-out read port
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic [DATA_W-1:0] sc_data,
  output logic              sc_valid,
  // frame timing / mode
  input  logic              vblank,
  input  logic              frame_start,
  input  logic              sync_mode,
  // writer 0 (keyboard / text terminal)
  input  logic              w0_valid,
  output logic              w0_ready,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  // writer 1 (host / CPU)
  input  logic              w1_valid,
  output logic              w1_ready,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // statistics
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             sc_grant;
  logic             write_window;
  logic [1:0]       wr_req;
  logic [1:0]       wr_gnt;
  logic             stall;
  logic             sc_valid_q;
  logic             sc_valid_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Scan-out may use the RAM whenever it asks, except during reset
  assign sc_grant = sc_req && !reset;

  // Writes need a free slot and, in tear-free mode, vertical blanking
  assign write_window = !sc_req && (!sync_mode || vblank);
  assign wr_req       = {w1_valid, w0_valid} & {2{write_window}};

  rr_arb2 u_rr_arb2 (
    .clock (clock),
    .reset (reset),
    .en_i  (!reset),
    .req_i (wr_req),
    .gnt_o (wr_gnt)
  );

  assign w0_ready = wr_gnt[0];
  assign w1_ready = wr_gnt[1];

  // Drive the RAM from whichever requester owns this cycle; idle drives 0
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sc_grant) begin
      mem_en   = 1'b1;
      mem_addr = sc_addr;
    end else if (wr_gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w0_addr;
      mem_wdata = w0_data;
    end else if (wr_gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w1_addr;
      mem_wdata = w1_data;
    end
  end

  // A writer is stalled when it presents data that is not accepted
  assign stall = (w0_valid && !w0_ready) || (w1_valid && !w1_ready);

  // Next-state for read-valid pipeline and saturating stall counter
  always_comb begin
    sc_valid_d  = sc_grant;
    stall_cnt_d = stall_cnt_q;
    if (frame_start) begin
      stall_cnt_d = '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Registered read-valid flag and stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sc_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sc_valid_q  <= sc_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // RAM has one cycle of latency, so read data lines up with sc_valid
  assign sc_data   = mem_rdata;
  assign sc_valid  = sc_valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
